stopwatch_ctrl: RTL and testbench

//  Sequencer for the chained BCD digit counters of the stopwatch display.

---
 rtl/stopwatch_ctrl.sv | 119 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: prescales clk into digit count pulses and runs the
// start/stop/lap/clear/overflow state machine for the BCD digit chain.
module stopwatch_ctrl #(
  parameter int unsigned PRESCALE  = 1_000_000,
  parameter int unsigned CNT_WIDTH = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       top_carry,
  output logic       increase,
  output logic       load_def,
  output logic       freeze,
  output logic       running,
  output logic       overflow,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    OVF   = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(PRESCALE - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 inc_d, load_d, freeze_d, ovf_d;
  logic                 wrap;

  assign wrap = (cnt_q == LAST_CNT);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    inc_d    = 1'b0;
    load_d   = 1'b0;
    freeze_d = freeze;
    ovf_d    = overflow;

    if (clear) begin
      // Digits only honour load_def while increase is high, so both pulse together.
      state_d  = IDLE;
      cnt_d    = '0;
      freeze_d = 1'b0;
      ovf_d    = 1'b0;
      inc_d    = 1'b1;
      load_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_stop) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN, LAP: begin
          if (increase && top_carry) begin
            // The chain wrapped on the edge that carried this increase.
            state_d  = OVF;
            cnt_d    = '0;
            freeze_d = 1'b0;
            ovf_d    = 1'b1;
          end else if (start_stop) begin
            // Prescaler holds from this edge so a resume loses no partial step.
            state_d  = PAUSE;
            freeze_d = 1'b0;
          end else begin
            cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
            inc_d = wrap;
            if (lap) begin
              state_d  = (state_q == RUN) ? LAP : RUN;
              freeze_d = (state_q == RUN);
            end
          end
        end
        PAUSE: begin
          if (start_stop) state_d = RUN;
        end
        OVF: begin
          state_d = OVF;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      increase <= 1'b0;
      load_def <= 1'b0;
      freeze   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      increase <= inc_d;
      load_def <= load_d;
      freeze   <= freeze_d;
      overflow <= ovf_d;
    end
  end

  assign state   = state_q;
  assign running = (state_q == RUN) || (state_q == LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with PRESCALE=4: an elapsed-time
// model checked every cycle plus directed scenarios with literal expectations.
module tb_stopwatch_ctrl;

  localparam int P = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3, M_OVF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0, lap = 1'b0, clear = 1'b0, top_carry = 1'b0;
  logic       increase, load_def, freeze, running, overflow;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int n;

  stopwatch_ctrl #(.PRESCALE(P), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
    .top_carry(top_carry), .increase(increase), .load_def(load_def),
    .freeze(freeze), .running(running), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks elapsed counting cycles since the stopwatch was started;
  // a step is due whenever that elapsed time is a whole multiple of P.
  int m_mode = M_IDLE, m_elapsed = 0;
  bit m_inc = 0, m_ld = 0, m_frz = 0, m_ovf = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_elapsed = 0;
      m_inc = 0; m_ld = 0; m_frz = 0; m_ovf = 0;
    end else begin
      automatic bit step_shown = m_inc;
      m_inc = 0; m_ld = 0;
      if (clear) begin
        m_mode = M_IDLE; m_elapsed = 0; m_frz = 0; m_ovf = 0;
        m_inc = 1; m_ld = 1;
      end else if (m_mode == M_IDLE) begin
        if (start_stop) begin m_mode = M_RUN; m_elapsed = 0; end
      end else if (m_mode == M_PAUSE) begin
        if (start_stop) m_mode = M_RUN;
      end else if (m_mode == M_RUN || m_mode == M_LAP) begin
        if (step_shown && top_carry) begin
          m_mode = M_OVF; m_ovf = 1; m_frz = 0;
        end else if (start_stop) begin
          m_mode = M_PAUSE; m_frz = 0;
        end else begin
          m_elapsed++;
          m_inc = (m_elapsed % P == 0);
          if (lap) begin
            m_frz  = !m_frz;
            m_mode = m_frz ? M_LAP : M_RUN;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_state",    state,    m_mode);
      check("m_increase", increase, m_inc);
      check("m_load_def", load_def, m_ld);
      check("m_freeze",   freeze,   m_frz);
      check("m_overflow", overflow, m_ovf);
      check("m_running",  running,  (m_mode == M_RUN || m_mode == M_LAP));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Cycles until increase is seen; 99 if it never comes within the bound.
  task automatic wait_inc(output int cnt);
    cnt = 99;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (increase) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_state", state, 0);
    check("reset_outs", {increase, load_def, freeze, overflow, running}, 5'b0);
    @(posedge clk); #1 rst = 1'b0;
    cycle();

    // 1: start and periodic pulses at 4, 8, 12
    start_stop = 1; cycle(); start_stop = 0;
    check("t1_state", state, 1);
    wait_inc(n); check("t1_first_at_4", n, 4);
    cycle();     check("t1_width", increase, 0);
    wait_inc(n); check("t1_second_at_8", n + 5, 8);
    wait_inc(n); check("t1_third_at_12", n, 4);

    // 2: pause one cycle after a pulse, hold 10 cycles, resume
    cycle();
    start_stop = 1; cycle(); start_stop = 0;
    check("t2_paused", state, 2);
    n = 0;
    for (int i = 0; i < 10; i++) begin cycle(); n += increase; end
    check("t2_no_inc_paused", n, 0);
    start_stop = 1; cycle(); start_stop = 0;
    check("t2_resumed", state, 1);
    wait_inc(n); check("t2_resume_at_3", n, 3);

    // 3: lap freezes without disturbing the period
    lap = 1; cycle(); lap = 0;
    check("t3_lap_state", state, 3);
    check("t3_freeze_on", freeze, 1);
    wait_inc(n); check("t3_lap_first", n, 3);
    wait_inc(n); check("t3_lap_period", n, 4);
    check("t3_still_frozen", freeze, 1);
    lap = 1; cycle(); lap = 0;
    check("t3_unlap_state", state, 1);
    check("t3_freeze_off", freeze, 0);
    wait_inc(n); check("t3_unlap_first", n, 3);
    wait_inc(n); check("t3_unlap_period", n, 4);

    // 4: clear beats start_stop in the same cycle
    cycle();
    clear = 1; start_stop = 1; cycle(); clear = 0; start_stop = 0;
    check("t4_idle", state, 0);
    check("t4_load_inc", {load_def, increase}, 2'b11);
    cycle();
    check("t4_one_cycle", {load_def, increase}, 2'b00);
    check("t4_still_idle", state, 0);

    // 5: carry without increase is ignored; carry with increase overflows
    start_stop = 1; cycle(); start_stop = 0;
    cycle();
    top_carry = 1; cycle(); top_carry = 0;
    check("t5_glitch_ignored", state, 1);
    wait_inc(n); check("t5_pulse_at_4", n, 2);
    top_carry = 1; cycle(); top_carry = 0;
    check("t5_ovf_state", state, 4);
    check("t5_ovf_flags", {overflow, increase, running, freeze}, 4'b1000);
    n = 0;
    for (int i = 0; i < 8; i++) begin cycle(); n += increase; end
    check("t5_no_inc_ovf", n, 0);
    start_stop = 1; cycle(); start_stop = 0;
    check("t5_ss_ignored", state, 4);
    clear = 1; cycle(); clear = 0;
    check("t5_clear_idle", state, 0);
    check("t5_ovf_cleared", overflow, 0);
    check("t5_clear_load", {load_def, increase}, 2'b11);
    cycle();

    // 6: async reset mid-count, then restart
    start_stop = 1; cycle(); start_stop = 0;
    cycle(); cycle();
    #2 rst = 1; #1;
    check("t6_rst_state", state, 0);
    check("t6_rst_outs", {increase, load_def, freeze, overflow, running}, 5'b0);
    cycle();
    check("t6_rst_held", {increase, load_def}, 2'b0);
    rst = 0;
    cycle();
    start_stop = 1; cycle(); start_stop = 0;
    wait_inc(n); check("t6_restart_at_4", n, 4);
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
